// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions used by fetch, decode and csr: fetch FSM state
// encodings, the opcodes and SYSTEM instruction words the front end cares
// about, and the default reset PC.
package fetch_ctrl_pkg;

    // Fetch FSM state encodings.
    localparam logic [1:0] FETCH_REQ   = 2'b00;
    localparam logic [1:0] FETCH_WAIT  = 2'b01;
    localparam logic [1:0] FETCH_HOLD  = 2'b10;
    localparam logic [1:0] FETCH_SLEEP = 2'b11;

    // RV32 major opcodes that change control flow.
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Full instruction words for privileged return and wait-for-interrupt.
    localparam logic [31:0] INSN_MRET = 32'h3020_0073;
    localparam logic [31:0] INSN_WFI  = 32'h1050_0073;

    // Default PC after reset.
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: single-entry instruction holding register between the fetch
// FSM and decode. A flush beats a load, a load beats consumption, and with
// none of them the entry holds so decode sees stable data under stall.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] pc_i,
    input  logic         consume_i,
    input  logic         flush_i,
    output logic         valid_o,
    output logic [W-1:0] inst_o,
    output logic [W-1:0] pc_o
);

    logic         valid_q;
    logic [W-1:0] inst_q;
    logic [W-1:0] pc_q;

    // Holding register update; the data fields only change on a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= {W{1'b0}};
            pc_q    <= {W{1'b0}};
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= data_i;
            pc_q    <= pc_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the architectural PC, issues one instruction-memory
// request at a time, applies execute redirects (killing in-flight stale
// responses) and hands fetched words to decode through fetch_buf.
// Optional macro FETCH_WFI_EN enables the SLEEP state (wfi/irq); without it
// wfi and irq are ignored and the SLEEP encoding behaves as REQ.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned  W        = 32,
    parameter logic [W-1:0] RESET_PC = W'(FETCH_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    input  logic         redirect,
    input  logic [W-1:0] redirect_pc,
    input  logic         stall,
    output logic         inst_valid,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    input  logic         wfi,
    input  logic         irq
);

    logic [1:0]   state_q, state_d, state_eff_s;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] req_pc_q, req_pc_d;
    logic [W-1:0] pc_inc_s, redir_pc_s;
    logic         kill_q, kill_d;
    logic         wfi_pend_q, wfi_pend_d;
    logic         wfi_in_s, irq_in_s, sleep_req_s;
    logic         buf_load_s, buf_consume_s;
    logic         unused_s;

`ifdef FETCH_WFI_EN
    assign wfi_in_s    = wfi;
    assign irq_in_s    = irq;
    assign state_eff_s = state_q;
    assign unused_s    = ^redirect_pc[1:0];
`else
    assign wfi_in_s    = 1'b0;
    assign irq_in_s    = 1'b0;
    assign state_eff_s = (state_q == FETCH_SLEEP) ? FETCH_REQ : state_q;
    assign unused_s    = ^{wfi, irq, redirect_pc[1:0]};
`endif

    // Targets are word aligned; sequential PC wraps modulo 2^W.
    assign redir_pc_s    = {redirect_pc[W-1:2], 2'b00};
    assign pc_inc_s      = pc_q + W'(32'd4);
    // A wfi seen while waiting is remembered until the held word is consumed.
    assign sleep_req_s   = wfi_in_s | wfi_pend_q;
    assign buf_consume_s = (state_eff_s == FETCH_HOLD) && !stall;

    // Next-state, PC and kill logic; redirect outranks every other event.
    always_comb begin
        state_d    = state_eff_s;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        wfi_pend_d = wfi_pend_q;
        buf_load_s = 1'b0;
        case (state_eff_s)
            FETCH_REQ: begin
                if (imem_gnt) begin
                    // A grant in the redirect cycle carries the old address.
                    state_d  = FETCH_WAIT;
                    req_pc_d = pc_q;
                    kill_d   = redirect;
                    pc_d     = redirect ? redir_pc_s : pc_inc_s;
                end else if (redirect) begin
                    pc_d = redir_pc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            FETCH_WAIT: begin
                wfi_pend_d = !redirect && (wfi_pend_q || wfi_in_s);
                pc_d       = redirect ? redir_pc_s : pc_q;
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (redirect || kill_q) begin
                        state_d = FETCH_REQ;
                    end else begin
                        state_d    = FETCH_HOLD;
                        buf_load_s = 1'b1;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            FETCH_HOLD: begin
                if (redirect) begin
                    state_d    = FETCH_REQ;
                    pc_d       = redir_pc_s;
                    wfi_pend_d = 1'b0;
                end else if (!stall) begin
                    state_d    = sleep_req_s ? FETCH_SLEEP : FETCH_REQ;
                    wfi_pend_d = 1'b0;
                end else begin
                    state_d = FETCH_HOLD;
                end
            end
            FETCH_SLEEP: begin
                if (redirect) begin
                    state_d = FETCH_REQ;
                    pc_d    = redir_pc_s;
                end else if (irq_in_s) begin
                    state_d = FETCH_REQ;
                end else begin
                    state_d = FETCH_SLEEP;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    // Architectural fetch state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= {W{1'b0}};
            kill_q     <= 1'b0;
            wfi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            wfi_pend_q <= wfi_pend_d;
        end
    end

    assign imem_req  = rst_n && (state_eff_s == FETCH_REQ);
    assign imem_addr = pc_q;

    fetch_buf #(
        .W (W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (buf_load_s),
        .data_i    (imem_rdata),
        .pc_i      (req_pc_q),
        .consume_i (buf_consume_s),
        .flush_i   (redirect),
        .valid_o   (inst_valid),
        .inst_o    (inst),
        .pc_o      (inst_pc)
    );

endmodule
